// File: rtl/sr_latch_ctrl.sv
// -----------------------------------------------------------------------------
// sr_latch_ctrl
//
// Sequences an external SR latch through its s/r pins. Set and clear requests
// are sampled only in IDLE. A tie is resolved round-robin, and clear wins the
// first tie after reset. The granted drive is held high for PULSE_CYCLES
// cycles. It is followed by GAP_CYCLES quiet cycles and then a single CHECK
// cycle. In CHECK the q/qbar feedback is compared with the granted operation
// and ack is pulsed. s and r are never high together.
//
// Optional feature: define SR_LATCH_CTRL_ERRCNT_EN to add a saturating 8-bit
// count of feedback mismatches on output err_cnt.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   set_req    level request to set the latch (hold until ack)
//   clr_req    level request to clear the latch (hold until ack)
//   ack        one-cycle pulse when the granted operation completes
//   grant_set  valid with ack: 1 = set serviced, 0 = clear serviced
//   busy       high in every state except IDLE
//   s, r       registered drives to the latch
//   q_fb       latch q feedback
//   qbar_fb    latch qbar feedback
//   state_q    last value written to the latch
//   err        sticky feedback-mismatch flag
//   err_clr    synchronous clear of err (and err_cnt)
//   err_cnt    mismatch count, saturating at 255 (only with the macro)
// -----------------------------------------------------------------------------
module sr_latch_ctrl #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       ack,
  output logic       grant_set,
  output logic       busy,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  input  logic       qbar_fb,
  output logic       state_q,
  output logic       err,
`ifdef SR_LATCH_CTRL_ERRCNT_EN
  output logic [7:0] err_cnt,
`endif
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_set_q, op_set_d;     // operation currently in flight
  logic             last_set_q, last_set_d; // last granted op, for tie-breaks
  logic             latch_val_q, latch_val_d;
  logic             err_q, err_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             ack_q, ack_d;
  logic             grant_set_q, grant_set_d;
  logic             busy_q, busy_d;
  logic             mismatch_s;

`ifdef SR_LATCH_CTRL_ERRCNT_EN
  logic [7:0]       err_cnt_q, err_cnt_d;
`endif

  // Next-state, counter and output-register decode.
  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    op_set_d    = op_set_q;
    last_set_d  = last_set_q;
    latch_val_d = latch_val_q;
    mismatch_s  = 1'b0;

    case (fsm_q)
      ST_IDLE: begin
        if (set_req && clr_req) begin
          // Tie: grant the opposite of whatever was granted last.
          op_set_d   = ~last_set_q;
          last_set_d = ~last_set_q;
          fsm_d      = ST_PULSE;
          cnt_d      = PULSE_LD;
        end else if (set_req || clr_req) begin
          op_set_d   = set_req;
          last_set_d = set_req;
          fsm_d      = ST_PULSE;
          cnt_d      = PULSE_LD;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (cnt_q <= CNT_ONE) begin
          if (GAP_CYCLES > 0) begin
            fsm_d = ST_GAP;
            cnt_d = GAP_LD;
          end else begin
            fsm_d = ST_CHECK;
            cnt_d = CNT_ZERO;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q <= CNT_ONE) begin
          fsm_d = ST_CHECK;
          cnt_d = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_CHECK: begin
        // A valid latch has complementary outputs and q equal to the written value.
        mismatch_s  = (q_fb != op_set_q) || (q_fb == qbar_fb);
        latch_val_d = op_set_q;
        fsm_d       = ST_IDLE;
      end
      default: begin
        fsm_d = ST_IDLE;
        cnt_d = CNT_ZERO;
      end
    endcase

    // The outputs are registered from the next state, so each drive changes
    // in the same cycle as the state it belongs to.
    s_d         = (fsm_d == ST_PULSE) &&  op_set_d;
    r_d         = (fsm_d == ST_PULSE) && !op_set_d;
    ack_d       = (fsm_d == ST_CHECK);
    grant_set_d = (fsm_d == ST_CHECK) && op_set_d;
    busy_d      = (fsm_d != ST_IDLE);

    // A mismatch that arrives together with err_clr still sets err.
    err_d = (err_q && !err_clr) || mismatch_s;
  end

`ifdef SR_LATCH_CTRL_ERRCNT_EN
  // Saturating mismatch counter; a mismatch together with err_clr restarts it at one.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (mismatch_s) begin
      if (err_clr) begin
        err_cnt_d = 8'd1;
      end else if (err_cnt_q != 8'd255) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else if (err_clr) begin
      err_cnt_d = 8'd0;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Mismatch counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  // State, counter and output registers. Reset clears s and r at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      op_set_q    <= 1'b0;
      last_set_q  <= 1'b1;  // makes clear win the first tie after reset
      latch_val_q <= 1'b0;
      err_q       <= 1'b0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      ack_q       <= 1'b0;
      grant_set_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      op_set_q    <= op_set_d;
      last_set_q  <= last_set_d;
      latch_val_q <= latch_val_d;
      err_q       <= err_d;
      s_q         <= s_d;
      r_q         <= r_d;
      ack_q       <= ack_d;
      grant_set_q <= grant_set_d;
      busy_q      <= busy_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign ack       = ack_q;
  assign grant_set = grant_set_q;
  assign busy      = busy_q;
  assign state_q   = latch_val_q;
  assign err       = err_q;

endmodule
